// File: rtl/etapa_id_ex_cortocircuito_if.sv
`default_nettype none
// ============================================================================
//  Module   : etapa_id_ex_cortocircuito_if
//  Brief    : ID/EX bus. It carries the operands and control decoded in ID,
//             the writers of later stages, and the registered EX view with
//             the forwarding and stall signals.
//  Revision : 1.0 - first release
// ============================================================================
interface etapa_id_ex_cortocircuito_if #(
    parameter int ANCHO_DATO = 32,
    parameter int ANCHO_REG  = 5,
    parameter int ANCHO_CONT = 16
);
    // ID side
    logic [ANCHO_DATO-1:0] DatoRs;
    logic [ANCHO_DATO-1:0] DatoRt;
    logic [ANCHO_REG-1:0]  Rs;
    logic [ANCHO_REG-1:0]  Rt;
    logic [ANCHO_REG-1:0]  Rd;
    logic                  RegWrite;
    logic                  MemRead;
    logic                  Valido;
    logic                  Flush;
    // Writers further down the pipe
    logic                  RegWrite_EXMEM;
    logic [ANCHO_REG-1:0]  RegDest_EXMEM;
    logic                  RegWrite_MEMWB;
    logic [ANCHO_REG-1:0]  RegDest_MEMWB;
    // EX side
    logic [ANCHO_DATO-1:0] DatoA_EX;
    logic [ANCHO_DATO-1:0] DatoB_EX;
    logic [ANCHO_REG-1:0]  Rs_EX;
    logic [ANCHO_REG-1:0]  Rt_EX;
    logic [ANCHO_REG-1:0]  Rd_EX;
    logic                  RegWrite_EX;
    logic                  MemRead_EX;
    logic                  Valido_EX;
    logic [1:0]            SelA;
    logic [1:0]            SelB;
    logic                  Stall;
    logic [ANCHO_CONT-1:0] ContStall;

    modport master (
        output DatoRs, DatoRt, Rs, Rt, Rd, RegWrite, MemRead, Valido, Flush,
        output RegWrite_EXMEM, RegDest_EXMEM, RegWrite_MEMWB, RegDest_MEMWB,
        input  DatoA_EX, DatoB_EX, Rs_EX, Rt_EX, Rd_EX,
        input  RegWrite_EX, MemRead_EX, Valido_EX,
        input  SelA, SelB, Stall, ContStall
    );

    modport slave (
        input  DatoRs, DatoRt, Rs, Rt, Rd, RegWrite, MemRead, Valido, Flush,
        input  RegWrite_EXMEM, RegDest_EXMEM, RegWrite_MEMWB, RegDest_MEMWB,
        output DatoA_EX, DatoB_EX, Rs_EX, Rt_EX, Rd_EX,
        output RegWrite_EX, MemRead_EX, Valido_EX,
        output SelA, SelB, Stall, ContStall
    );
endinterface
`default_nettype wire

// File: rtl/etapa_id_ex_cortocircuito.sv
`default_nettype none
// ============================================================================
//  Module   : etapa_id_ex_cortocircuito
//  Brief    : ID/EX pipeline register. It generates the forwarding selects
//             for the two EX operand muxes and detects load-use hazards.
//             On a hazard it stalls IF/ID for one cycle, inserts a bubble
//             into EX and counts the stall cycles (saturating).
//  Revision : 1.0 - first release
// ============================================================================
module etapa_id_ex_cortocircuito #(
    parameter int ANCHO_DATO = 32,
    parameter int ANCHO_REG  = 5,
    parameter int ANCHO_CONT = 16
) (
    input  wire logic                   Clk,
    input  wire logic                   Reset,
    etapa_id_ex_cortocircuito_if.slave  bus
);
    // Operand mux select encoding
    localparam logic [1:0] c_SEL_RF    = 2'd0;
    localparam logic [1:0] c_SEL_EXMEM = 2'd1;
    localparam logic [1:0] c_SEL_MEMWB = 2'd2;

    logic [ANCHO_DATO-1:0] r_datoA;
    logic [ANCHO_DATO-1:0] r_datoB;
    logic [ANCHO_REG-1:0]  r_rsEx;
    logic [ANCHO_REG-1:0]  r_rtEx;
    logic [ANCHO_REG-1:0]  r_rdEx;
    logic                  r_regWriteEx;
    logic                  r_memReadEx;
    logic                  r_validoEx;
    logic [ANCHO_CONT-1:0] r_contStall;

    logic                  w_stall;
    logic [ANCHO_REG-1:0]  w_idx [2];
    logic [1:0][1:0]       w_sel;

    // A load in EX whose destination is read by the instruction in ID.
    // Register $0 is never a real dependency.
    assign w_stall = r_validoEx & r_memReadEx & bus.Valido
                   & (r_rtEx != '0)
                   & ((r_rtEx == bus.Rs) | (r_rtEx == bus.Rt));

    // ID/EX register: reset, then flush/stall bubble, then normal capture
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_datoA      <= '0;
            r_datoB      <= '0;
            r_rsEx       <= '0;
            r_rtEx       <= '0;
            r_rdEx       <= '0;
            r_regWriteEx <= 1'b0;
            r_memReadEx  <= 1'b0;
            r_validoEx   <= 1'b0;
        end else if (bus.Flush || w_stall) begin
            r_datoA      <= '0;
            r_datoB      <= '0;
            r_rsEx       <= '0;
            r_rtEx       <= '0;
            r_rdEx       <= '0;
            r_regWriteEx <= 1'b0;
            r_memReadEx  <= 1'b0;
            r_validoEx   <= 1'b0;
        end else begin
            r_datoA      <= bus.DatoRs;
            r_datoB      <= bus.DatoRt;
            r_rsEx       <= bus.Rs;
            r_rtEx       <= bus.Rt;
            r_rdEx       <= bus.Rd;
            r_regWriteEx <= bus.RegWrite & bus.Valido;
            r_memReadEx  <= bus.MemRead & bus.Valido;
            r_validoEx   <= bus.Valido;
        end
    end

    // Saturating stall-cycle counter; counts even when Flush is asserted
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_contStall <= '0;
        end else if (w_stall && (r_contStall != '1)) begin
            r_contStall <= r_contStall + ANCHO_CONT'(1);
        end
    end

    assign w_idx[0] = r_rsEx;
    assign w_idx[1] = r_rtEx;

    // Per-operand forwarding: EX/MEM is the youngest producer, so it wins
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        logic w_hitExMem;
        logic w_hitMemWb;

        assign w_hitExMem = bus.RegWrite_EXMEM & (bus.RegDest_EXMEM != '0)
                          & (bus.RegDest_EXMEM == w_idx[gi]);
        assign w_hitMemWb = bus.RegWrite_MEMWB & (bus.RegDest_MEMWB != '0)
                          & (bus.RegDest_MEMWB == w_idx[gi]);
        assign w_sel[gi]  = !r_validoEx ? c_SEL_RF    :
                            w_hitExMem  ? c_SEL_EXMEM :
                            w_hitMemWb  ? c_SEL_MEMWB : c_SEL_RF;
    end

    assign bus.DatoA_EX    = r_datoA;
    assign bus.DatoB_EX    = r_datoB;
    assign bus.Rs_EX       = r_rsEx;
    assign bus.Rt_EX       = r_rtEx;
    assign bus.Rd_EX       = r_rdEx;
    assign bus.RegWrite_EX = r_regWriteEx;
    assign bus.MemRead_EX  = r_memReadEx;
    assign bus.Valido_EX   = r_validoEx;
    assign bus.SelA        = w_sel[0];
    assign bus.SelB        = w_sel[1];
    assign bus.Stall       = w_stall;
    assign bus.ContStall   = r_contStall;

endmodule
`default_nettype wire

// File: tb/tb_etapa_id_ex_cortocircuito.sv
`default_nettype none
// ============================================================================
//  Module   : tb_etapa_id_ex_cortocircuito
//  Brief    : Bench for the ID/EX register with forwarding and load-use
//             detection. It uses a directed vector table, a randomized phase
//             against a reference model, and a counter-saturation sequence
//             on a second instance that has a narrow counter.
//  Revision : 1.0 - first release
// ============================================================================
module tb_etapa_id_ex_cortocircuito;
    localparam int c_W2 = 4;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Stimulus shared by both instances
    logic        tReset, tFlush, tValido, tMemRead, tRegWrite;
    logic [4:0]  tRs, tRt, tRd;
    logic [31:0] tDatoRs, tDatoRt;
    logic        tRwX, tRwW;
    logic [4:0]  tRdX, tRdW;

    etapa_id_ex_cortocircuito_if #(.ANCHO_DATO(32), .ANCHO_REG(5), .ANCHO_CONT(16)) bus1 ();
    etapa_id_ex_cortocircuito_if #(.ANCHO_DATO(32), .ANCHO_REG(5), .ANCHO_CONT(c_W2)) bus2 ();

    assign bus1.DatoRs = tDatoRs;  assign bus2.DatoRs = tDatoRs;
    assign bus1.DatoRt = tDatoRt;  assign bus2.DatoRt = tDatoRt;
    assign bus1.Rs = tRs;          assign bus2.Rs = tRs;
    assign bus1.Rt = tRt;          assign bus2.Rt = tRt;
    assign bus1.Rd = tRd;          assign bus2.Rd = tRd;
    assign bus1.RegWrite = tRegWrite; assign bus2.RegWrite = tRegWrite;
    assign bus1.MemRead = tMemRead;   assign bus2.MemRead = tMemRead;
    assign bus1.Valido = tValido;     assign bus2.Valido = tValido;
    assign bus1.Flush = tFlush;       assign bus2.Flush = tFlush;
    assign bus1.RegWrite_EXMEM = tRwX; assign bus2.RegWrite_EXMEM = tRwX;
    assign bus1.RegDest_EXMEM = tRdX;  assign bus2.RegDest_EXMEM = tRdX;
    assign bus1.RegWrite_MEMWB = tRwW; assign bus2.RegWrite_MEMWB = tRwW;
    assign bus1.RegDest_MEMWB = tRdW;  assign bus2.RegDest_MEMWB = tRdW;

    etapa_id_ex_cortocircuito #(.ANCHO_DATO(32), .ANCHO_REG(5), .ANCHO_CONT(16)) dut (
        .Clk(Clk), .Reset(tReset), .bus(bus1)
    );
    etapa_id_ex_cortocircuito #(.ANCHO_DATO(32), .ANCHO_REG(5), .ANCHO_CONT(c_W2)) dut2 (
        .Clk(Clk), .Reset(tReset), .bus(bus2)
    );

    int nTests = 0;
    int nFail  = 0;

    // Reference model: the instruction that currently sits in EX
    logic [31:0] mA, mB;
    logic [4:0]  mRs, mRt, mRd;
    logic        mRw, mMr, mV;
    int          mCnt, mCnt2;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic expStall();
        return mV && mMr && tValido && (mRt != 0) && (mRt == tRs || mRt == tRt);
    endfunction

    function automatic logic [1:0] expSel(input logic [4:0] idx);
        if (!mV) return 2'd0;
        if (tRwX && tRdX != 0 && tRdX == idx) return 2'd1;
        if (tRwW && tRdW != 0 && tRdW == idx) return 2'd2;
        return 2'd0;
    endfunction

    task automatic modelEdge();
        logic st;
        st = expStall();
        if (!tReset) begin
            {mA, mB, mRs, mRt, mRd, mRw, mMr, mV} = '0;
            mCnt = 0;
            mCnt2 = 0;
        end else begin
            if (st) begin
                if (mCnt < 65535) mCnt++;
                if (mCnt2 < (1 << c_W2) - 1) mCnt2++;
            end
            if (tFlush || st) begin
                {mA, mB, mRs, mRt, mRd, mRw, mMr, mV} = '0;
            end else begin
                mA = tDatoRs; mB = tDatoRt;
                mRs = tRs; mRt = tRt; mRd = tRd;
                mRw = tRegWrite && tValido;
                mMr = tMemRead && tValido;
                mV = tValido;
            end
        end
    endtask

    task automatic checkModel();
        chk("DatoA_EX", 64'(bus1.DatoA_EX), 64'(mA));
        chk("DatoB_EX", 64'(bus1.DatoB_EX), 64'(mB));
        chk("Rs_EX", 64'(bus1.Rs_EX), 64'(mRs));
        chk("Rt_EX", 64'(bus1.Rt_EX), 64'(mRt));
        chk("Rd_EX", 64'(bus1.Rd_EX), 64'(mRd));
        chk("RegWrite_EX", 64'(bus1.RegWrite_EX), 64'(mRw));
        chk("MemRead_EX", 64'(bus1.MemRead_EX), 64'(mMr));
        chk("Valido_EX", 64'(bus1.Valido_EX), 64'(mV));
        chk("SelA", 64'(bus1.SelA), 64'(expSel(mRs)));
        chk("SelB", 64'(bus1.SelB), 64'(expSel(mRt)));
        chk("Stall", 64'(bus1.Stall), 64'(expStall()));
        chk("ContStall", 64'(bus1.ContStall), 64'(mCnt));
        chk("ContStall_narrow", 64'(bus2.ContStall), 64'(mCnt2));
    endtask

    // Inputs are set after a falling edge; checks happen 1 time unit later,
    // then the rising edge is taken and the model advances.
    task automatic tick(input logic doChk);
        #1;
        if (doChk) checkModel();
        @(posedge Clk);
        modelEdge();
        @(negedge Clk);
    endtask

    typedef struct {
        bit          chkOn;
        bit          rst, fl, v, mr, rw;
        logic [4:0]  rs, rt;
        logic [31:0] dRs, dRt;
        bit          rwX;
        logic [4:0]  rdX;
        bit          rwW;
        logic [4:0]  rdW;
        logic [31:0] eA, eB;
        bit          eV;
        logic [1:0]  eSA, eSB;
        bit          eSt;
        int          eCnt;
    } vec_t;

    vec_t vec [15];

    task automatic loadLoadUse(input logic isDep);
        tReset = 1; tFlush = 0; tValido = 1; tRegWrite = 1; tRd = 5'd4;
        tRwX = 0; tRdX = 0; tRwW = 0; tRdW = 0;
        tMemRead = !isDep;
        tRs = isDep ? 5'd7 : 5'd1;
        tRt = isDep ? 5'd2 : 5'd7;
        tDatoRs = $urandom; tDatoRt = $urandom;
    endtask

    initial begin
        //      chk rst fl v mr rw  rs rt  dRs          dRt  rwX rdX rwW rdW  eA    eB    eV sA sB st cnt
        vec[0]  = '{0, 0, 0, 1, 0, 1, 1, 2, 32'hDEADBEEF, 0,  0, 0, 0, 0,  0,    0,    0, 0, 0, 0, 0};
        vec[1]  = '{1, 1, 0, 1, 0, 1, 3, 4, 32'h2,  32'h4,   0, 0, 0, 0,  0,    0,    0, 0, 0, 0, 0};
        vec[2]  = '{1, 1, 0, 1, 0, 1, 5, 5, 32'h11, 32'h22,  0, 0, 0, 0,  2,    4,    1, 0, 0, 0, 0};
        vec[3]  = '{1, 1, 0, 1, 0, 1, 5, 5, 32'h11, 32'h22,  1, 5, 1, 5,  'h11, 'h22, 1, 1, 1, 0, 0};
        vec[4]  = '{1, 1, 0, 1, 0, 1, 5, 5, 32'h11, 32'h22,  0, 5, 1, 5,  'h11, 'h22, 1, 2, 2, 0, 0};
        vec[5]  = '{1, 1, 0, 1, 0, 1, 0, 0, 32'h33, 32'h44,  1, 0, 1, 0,  'h11, 'h22, 1, 0, 0, 0, 0};
        vec[6]  = '{1, 1, 0, 1, 1, 1, 1, 7, 32'h55, 32'h66,  1, 0, 1, 0,  'h33, 'h44, 1, 0, 0, 0, 0};
        vec[7]  = '{1, 1, 0, 1, 0, 1, 7, 2, 32'h77, 32'h88,  0, 0, 0, 0,  'h55, 'h66, 1, 0, 0, 1, 0};
        vec[8]  = '{1, 1, 0, 1, 0, 1, 7, 2, 32'h77, 32'h88,  1, 7, 0, 0,  0,    0,    0, 0, 0, 0, 1};
        vec[9]  = '{1, 1, 0, 1, 1, 1, 1, 9, 32'h0A, 32'h0B,  0, 0, 1, 7,  'h77, 'h88, 1, 2, 0, 0, 1};
        vec[10] = '{1, 1, 1, 1, 0, 1, 9, 0, 32'h0C, 32'h0D,  0, 0, 0, 0,  'h0A, 'h0B, 1, 0, 0, 1, 1};
        vec[11] = '{1, 1, 0, 0, 0, 0, 0, 0, 32'h0,  32'h0,   0, 0, 0, 0,  0,    0,    0, 0, 0, 0, 2};
        vec[12] = '{1, 1, 0, 1, 1, 1, 2, 3, 32'h99, 32'h98,  0, 0, 0, 0,  0,    0,    0, 0, 0, 0, 2};
        vec[13] = '{1, 0, 1, 1, 0, 1, 3, 1, 32'h1,  32'h2,   1, 3, 0, 0,  'h99, 'h98, 1, 0, 1, 1, 2};
        vec[14] = '{1, 1, 0, 0, 0, 0, 0, 0, 32'h0,  32'h0,   1, 3, 1, 3,  0,    0,    0, 0, 0, 0, 0};

        {tReset, tFlush, tValido, tMemRead, tRegWrite} = '0;
        {tRs, tRt, tRd, tDatoRs, tDatoRt, tRwX, tRdX, tRwW, tRdW} = '0;
        @(negedge Clk);

        // Directed vectors
        foreach (vec[i]) begin
            tReset = vec[i].rst; tFlush = vec[i].fl; tValido = vec[i].v;
            tMemRead = vec[i].mr; tRegWrite = vec[i].rw;
            tRs = vec[i].rs; tRt = vec[i].rt; tRd = 5'd10;
            tDatoRs = vec[i].dRs; tDatoRt = vec[i].dRt;
            tRwX = vec[i].rwX; tRdX = vec[i].rdX; tRwW = vec[i].rwW; tRdW = vec[i].rdW;
            #1;
            if (vec[i].chkOn) begin
                chk($sformatf("vec%0d.DatoA_EX", i), 64'(bus1.DatoA_EX), 64'(vec[i].eA));
                chk($sformatf("vec%0d.DatoB_EX", i), 64'(bus1.DatoB_EX), 64'(vec[i].eB));
                chk($sformatf("vec%0d.Valido_EX", i), 64'(bus1.Valido_EX), 64'(vec[i].eV));
                chk($sformatf("vec%0d.SelA", i), 64'(bus1.SelA), 64'(vec[i].eSA));
                chk($sformatf("vec%0d.SelB", i), 64'(bus1.SelB), 64'(vec[i].eSB));
                chk($sformatf("vec%0d.Stall", i), 64'(bus1.Stall), 64'(vec[i].eSt));
                chk($sformatf("vec%0d.ContStall", i), 64'(bus1.ContStall), 64'(vec[i].eCnt));
            end
            tick(vec[i].chkOn);
        end

        // Randomized traffic against the model; small index range gives hits
        for (int n = 0; n < 1500; n++) begin
            tReset    = ($urandom_range(0, 49) != 0);
            tFlush    = ($urandom_range(0, 9) == 0);
            tValido   = ($urandom_range(0, 3) != 0);
            tMemRead  = 1'($urandom_range(0, 1));
            tRegWrite = 1'($urandom_range(0, 1));
            tRs = 5'($urandom_range(0, 3)); tRt = 5'($urandom_range(0, 3));
            tRd = 5'($urandom_range(0, 31));
            tDatoRs = $urandom; tDatoRt = $urandom;
            tRwX = 1'($urandom_range(0, 1)); tRdX = 5'($urandom_range(0, 3));
            tRwW = 1'($urandom_range(0, 1)); tRdW = 5'($urandom_range(0, 3));
            tick(1'b1);
        end

        // Counter saturation: 2^c_W2 + 3 stalls on the narrow instance
        loadLoadUse(1'b0);
        tReset = 0;
        tick(1'b0);
        for (int k = 0; k < (1 << c_W2) + 3; k++) begin
            loadLoadUse(1'b0);
            tick(1'b1);
            loadLoadUse(1'b1);
            #1;
            chk("sat.Stall", 64'(bus1.Stall), 64'd1);
            tick(1'b1);
        end
        #1;
        chk("sat.ContStall_narrow", 64'(bus2.ContStall), 64'hF);
        chk("sat.ContStall", 64'(bus1.ContStall), 64'd19);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
`default_nettype wire
